// File: rtl/esop_seq_eval_if.sv
// esop_seq_eval_if: groups the cube-loader config port and the input/result
// valid/ready streams of esop_seq_eval. The master side is the loader/producer,
// the slave side is the evaluator.
`timescale 1ns/1ps
interface esop_seq_eval_if #(
  parameter int N_IN      = 8,
  parameter int N_OUT     = 1,
  parameter int MAX_CUBES = 16
);
  localparam int AW = $clog2(MAX_CUBES);
  localparam int CW = 2 * N_IN + N_OUT;

  // config side
  logic            cube_we;
  logic [AW-1:0]   cube_addr;
  logic [CW-1:0]   cube_data;
  logic            num_we;
  logic [AW:0]     num_cubes;
  logic            cfg_busy;

  // input vector stream
  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] x;

  // result stream
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] y;

  modport master (
    output cube_we, cube_addr, cube_data, num_we, num_cubes,
    output in_valid, x, out_ready,
    input  cfg_busy, in_ready, out_valid, y
  );

  modport slave (
    input  cube_we, cube_addr, cube_data, num_we, num_cubes,
    input  in_valid, x, out_ready,
    output cfg_busy, in_ready, out_valid, y
  );
endinterface

// File: rtl/esop_seq_eval.sv
// esop_seq_eval: run-time programmable ESOP evaluator. Holds up to MAX_CUBES
// product terms over N_IN inputs; for each accepted input vector it walks the
// first K cubes and XOR-accumulates the output masks of the matching ones.
// Optional build macro ESOP_SEQ_EVAL_PAR2_EN: evaluate two cubes per EVAL cycle
// (results identical, latency roughly halved).
`timescale 1ns/1ps
module esop_seq_eval #(
  parameter int N_IN      = 8,
  parameter int N_OUT     = 1,
  parameter int MAX_CUBES = 16
) (
  input logic             clk,
  input logic             rst,
  esop_seq_eval_if.slave  bus
);
  localparam int AW = $clog2(MAX_CUBES);
  localparam int KW = AW + 1;
  localparam int CW = 2 * N_IN + N_OUT;
`ifdef ESOP_SEQ_EVAL_PAR2_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cube_mem [MAX_CUBES];
  logic [KW-1:0]    k_reg;
  logic [KW-1:0]    k_p0;
  logic [AW-1:0]    idx_p0;
  logic [N_IN-1:0]  x_p0;
  logic signed [N_OUT-1:0] acc_unused_sign_guard;
  logic [N_OUT-1:0] acc_p0;
  logic [N_OUT-1:0] y_q;
  logic [N_OUT-1:0] step_term;
  logic [KW-1:0]    idx_ext;
  logic             last_step;
  logic             accept;
  logic             cfg_open;
`ifdef ESOP_SEQ_EVAL_PAR2_EN
  logic [AW-1:0]    idx_nxt;
`endif

  // One literal: 00 don't-care, 01 needs x=1, 10 needs x=0, 11 never.
  function automatic logic lit_ok(input logic [1:0] lit, input logic xi);
    case (lit)
      2'b00:   return 1'b1;
      2'b01:   return xi;
      2'b10:   return ~xi;
      default: return 1'b0;
    endcase
  endfunction

  // Contribution of one cube: its output mask if every literal holds, else 0.
  function automatic logic [N_OUT-1:0] cube_term(input logic [CW-1:0] cube,
                                                 input logic [N_IN-1:0] xv);
    logic m;
    m = 1'b1;
    for (int i = 0; i < N_IN; i++) begin
      m &= lit_ok(cube[2*i +: 2], xv[i]);
    end
    return m ? cube[2*N_IN +: N_OUT] : '0;
  endfunction

  // Cube counts above the memory depth clamp to the full memory.
  function automatic logic [KW-1:0] sat_k(input logic [KW-1:0] n);
    return (n > KW'(MAX_CUBES)) ? KW'(MAX_CUBES) : n;
  endfunction

  assign cfg_open = (state == IDLE);
  assign accept   = bus.in_valid && cfg_open;
  assign bus.y    = y_q;
  assign acc_unused_sign_guard = '0;

  // Per-cycle contribution of the cube(s) at idx_p0 and end-of-list detection.
  always_comb begin
    idx_ext   = {1'b0, idx_p0};
    step_term = cube_term(cube_mem[idx_p0], x_p0);
`ifdef ESOP_SEQ_EVAL_PAR2_EN
    idx_nxt = idx_p0 + AW'(1);
    if (idx_ext + KW'(1) < k_p0) begin
      step_term = step_term ^ cube_term(cube_mem[idx_nxt], x_p0);
    end
    last_step = (idx_ext + KW'(2) >= k_p0);
`else
    last_step = (idx_ext + KW'(1) >= k_p0);
`endif
  end

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs decoded from the state.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.cfg_busy  = 1'b1;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.cfg_busy = 1'b0;
        if (bus.in_valid) state_nxt = (k_reg == '0) ? DONE : EVAL;
      end
      EVAL: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers: cube count, walk index and the published result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_reg  <= '0;
      idx_p0 <= '0;
      y_q    <= '0;
    end else begin
      if (bus.num_we && cfg_open) k_reg <= sat_k(bus.num_cubes);
      if (accept)                 idx_p0 <= '0;
      else if (state == EVAL)     idx_p0 <= idx_p0 + AW'(STEP);
      if (accept && (k_reg == '0))        y_q <= '0;
      else if ((state == EVAL) && last_step) y_q <= acc_p0 ^ step_term;
    end
  end

  // Stage p0 capture at accept (vector, frozen K, cleared accumulator), then accumulate.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_p0   <= bus.x;
      k_p0   <= k_reg;
      acc_p0 <= '0;
    end else if (state == EVAL) begin
      acc_p0 <= acc_p0 ^ step_term;
    end
  end

  // Cube memory, writable only while idle so in-flight evaluations are unaffected.
  always_ff @(posedge clk) begin
    if (bus.cube_we && cfg_open) cube_mem[bus.cube_addr] <= bus.cube_data;
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, acc_unused_sign_guard};
endmodule

// File: tb/tb_esop_seq_eval.sv
// tb_esop_seq_eval: directed table vectors, hand-written backpressure/reset
// sequences and randomized transactions against a cube-list reference model.
`timescale 1ns/1ps
module tb_esop_seq_eval;
  localparam int N_IN      = 8;
  localparam int N_OUT     = 2;
  localparam int MAX_CUBES = 16;
  localparam int CW        = 2 * N_IN + N_OUT;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [CW-1:0] model_mem [MAX_CUBES];
  int            model_k;

  esop_seq_eval_if #(.N_IN(N_IN), .N_OUT(N_OUT), .MAX_CUBES(MAX_CUBES)) bus();

  esop_seq_eval #(.N_IN(N_IN), .N_OUT(N_OUT), .MAX_CUBES(MAX_CUBES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    int         cfg;
    logic [7:0] x;
    logic [1:0] y;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int lat_for(input int k);
`ifdef ESOP_SEQ_EVAL_PAR2_EN
    return (k + 1) / 2;
`else
    return k;
`endif
  endfunction

  // Reference: XOR of masks of all matching cubes among the first model_k.
  function automatic logic [N_OUT-1:0] model_eval(input logic [N_IN-1:0] xv);
    logic [N_OUT-1:0] r;
    r = '0;
    for (int c = 0; c < model_k; c++) begin
      bit hit;
      hit = 1;
      for (int i = 0; i < N_IN; i++) begin
        int lit;
        lit = int'(model_mem[c][2*i +: 2]);
        if (!((lit == 0) || (lit != 3 && int'(xv[i]) == (lit % 2)))) hit = 0;
      end
      if (hit) r = r ^ model_mem[c][2*N_IN +: N_OUT];
    end
    return r;
  endfunction

  task automatic write_cube(input int addr, input logic [CW-1:0] data);
    bus.cube_we   = 1'b1;
    bus.cube_addr = addr[3:0];
    bus.cube_data = data;
    @(negedge clk);
    bus.cube_we   = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic set_k(input int n);
    bus.num_we    = 1'b1;
    bus.num_cubes = n[4:0];
    @(negedge clk);
    bus.num_we    = 1'b0;
    model_k = (n > MAX_CUBES) ? MAX_CUBES : n;
  endtask

  task automatic load_cfg(input int id);
    case (id)
      0: begin
        write_cube(0, {2'b01, 16'h0001});
        write_cube(1, {2'b01, 16'h0004});
        set_k(2);
      end
      1: begin
        write_cube(0, {2'b01, 16'h0020});
        write_cube(1, {2'b01, 16'h0003});
        set_k(2);
      end
      2: begin
        write_cube(0, {2'b01, 16'h0001});
        write_cube(1, {2'b10, 16'h0004});
        write_cube(2, {2'b11, 16'h0010});
        set_k(3);
      end
      default: set_k(0);
    endcase
  endtask

  task automatic start(input logic [7:0] xv);
    bus.in_valid = 1'b1;
    bus.x        = xv;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: out_valid never rose within 100 cycles", name);
    end
  endtask

  task automatic handshake(input string name);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({name, " out_valid after hs"}, bus.out_valid, 0);
    check({name, " in_ready after hs"}, bus.in_ready, 1);
  endtask

  task automatic run_vec(input string name, input logic [7:0] xv,
                         input logic [1:0] exp_y, input int exp_lat);
    int n;
    check({name, " in_ready idle"}, bus.in_ready, 1);
    start(xv);
    wait_valid(name, n);
    check({name, " latency"}, n, exp_lat);
    check({name, " y"}, bus.y, exp_y);
    handshake(name);
  endtask

  function automatic logic [CW-1:0] rand_cube();
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N_IN; i++) begin
      int r;
      r = $urandom_range(0, 11);
      c[2*i +: 2] = (r < 8) ? 2'b00 : (r < 10) ? 2'b01 : (r < 11) ? 2'b10 : 2'b11;
    end
    c[2*N_IN +: N_OUT] = 2'($urandom_range(0, 3));
    return c;
  endfunction

  initial begin
    int n;
    int cur;
    rst           = 1'b1;
    bus.cube_we   = 1'b0;
    bus.cube_addr = '0;
    bus.cube_data = '0;
    bus.num_we    = 1'b0;
    bus.num_cubes = '0;
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.out_ready = 1'b0;
    model_k       = 0;

    vecs[0]  = '{"pos x01",    0, 8'h01, 2'b01};
    vecs[1]  = '{"pos x03",    0, 8'h03, 2'b00};
    vecs[2]  = '{"pos x00",    0, 8'h00, 2'b00};
    vecs[3]  = '{"pos x02",    0, 8'h02, 2'b01};
    vecs[4]  = '{"neg x00",    1, 8'h00, 2'b01};
    vecs[5]  = '{"neg x04",    1, 8'h04, 2'b00};
    vecs[6]  = '{"neg xFF",    1, 8'hFF, 2'b00};
    vecs[7]  = '{"neg x03",    1, 8'h03, 2'b01};
    vecs[8]  = '{"mo all",     2, 8'h07, 2'b00};
    vecs[9]  = '{"mo cube2",   2, 8'h04, 2'b11};
    vecs[10] = '{"mo c0c1",    2, 8'h03, 2'b11};
    vecs[11] = '{"mo c0",      2, 8'h01, 2'b01};
    vecs[12] = '{"k0 xFF",     3, 8'hFF, 2'b00};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset out_valid", bus.out_valid, 0);
    check("reset y", bus.y, 0);
    check("reset in_ready", bus.in_ready, 1);
    check("reset cfg_busy", bus.cfg_busy, 0);
    run_vec("k0 after reset", 8'hFF, 2'b00, 0);

    // table-driven vectors
    cur = -1;
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].cfg != cur) begin
        load_cfg(vecs[i].cfg);
        cur = vecs[i].cfg;
      end
      run_vec(vecs[i].name, vecs[i].x, vecs[i].y, lat_for(model_k));
    end

    // backpressure: result held, pending vector and cube write ignored
    load_cfg(0);
    start(8'h01);
    wait_valid("bp", n);
    for (int c = 0; c < 5; c++) begin
      check("bp out_valid held", bus.out_valid, 1);
      check("bp y held", bus.y, 2'b01);
      check("bp in_ready low", bus.in_ready, 0);
      check("bp cfg_busy", bus.cfg_busy, 1);
      bus.in_valid  = 1'b1;
      bus.x         = 8'h03;
      bus.cube_we   = (c == 1);
      bus.cube_addr = '0;
      bus.cube_data = {2'b01, 16'h0003};
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.cube_we  = 1'b0;
    check("bp y after window", bus.y, 2'b01);
    handshake("bp");
    run_vec("bp cube0 kept", 8'h01, 2'b01, lat_for(model_k));

    // reset mid-EVAL: outputs clear at once and K returns to 0
    load_cfg(2);
    start(8'h07);
    check("midEVAL busy before rst", bus.cfg_busy, 1);
    rst = 1'b1;
    #1;
    check("midEVAL rst out_valid", bus.out_valid, 0);
    check("midEVAL rst y", bus.y, 0);
    check("midEVAL rst in_ready", bus.in_ready, 1);
    check("midEVAL rst cfg_busy", bus.cfg_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_k = 0;
    run_vec("K cleared by rst", 8'h07, 2'b00, 0);

    // reset mid-DONE
    load_cfg(2);
    start(8'h04);
    wait_valid("midDONE", n);
    check("midDONE y before rst", bus.y, 2'b11);
    rst = 1'b1;
    #1;
    check("midDONE rst out_valid", bus.out_valid, 0);
    check("midDONE rst y", bus.y, 0);
    check("midDONE rst in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_k = 0;

    // randomized transactions against the reference model
    for (int a = 0; a < MAX_CUBES; a++) write_cube(a, rand_cube());
    for (int t = 0; t < 40; t++) begin
      logic [7:0] xv;
      logic [1:0] ey;
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) write_cube($urandom_range(0, MAX_CUBES - 1), rand_cube());
      if ($urandom_range(0, 2) != 0) set_k($urandom_range(0, 20));
      xv = 8'($urandom);
      ey = model_eval(xv);
      start(xv);
      wait_valid("rand", n);
      check("rand latency", n, lat_for(model_k));
      check("rand y", bus.y, ey);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check("rand y hold", bus.y, ey);
      end
      handshake("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/esop_seq_eval.md
# esop_seq_eval

Sequential, run-time programmable ESOP (exclusive-sum-of-products) evaluator: it stores up to MAX_CUBES product terms over N_IN inputs and evaluates N_OUT output functions for one input vector per transaction by XOR-accumulating matching cubes. It is the generalised successor of the fixed, single-output 8-input ESOP benchmark netlists in the FHE-optimisation flow. The block lets one datapath evaluate any such function, hd08-class included, after loading its cube list. It sits between a cube-loader (config side) and a valid/ready stream of input vectors.

## Interface
- N_IN, 8, number of primary inputs per vector
- N_OUT, 1, number of output functions evaluated in parallel
- MAX_CUBES, 16, cube memory depth (power of two, ≥2)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cube_we  in  1  cube write strobe
- cube_addr  in  log2(MAX_CUBES)  cube slot
- cube_data  in  2*N_IN+N_OUT  literals in [2*N_IN-1:0] (literal i at [2i+1:2i]); output mask in [2*N_IN+N_OUT-1:2*N_IN]
- num_we  in  1  strobe to load active cube count
- num_cubes  in  log2(MAX_CUBES)+1  active cube count K, 0..MAX_CUBES (larger values saturate to MAX_CUBES)
- cfg_busy  out  1  high when not IDLE; config writes ignored
- in_valid / in_ready  in/out  1  input vector handshake
- x  in  N_IN  input vector
- out_valid / out_ready  out/in  1  result handshake
- y  out  N_OUT  result

## Operation
- Literal code: 00 don't-care; 01 requires x[i]=1; 10 requires x[i]=0; 11 cube never matches.
- Cube c matches when all literals are satisfied. y = XOR over c<K of (match(c) ? mask(c) : 0).
- States: IDLE → EVAL on in_valid&&in_ready (captures x, clears accumulator, index=0). EVAL processes one cube per cycle; index==K-1 → DONE. K=0 goes IDLE → DONE directly. DONE holds out_valid; on out_ready → IDLE.
- in_ready = (state==IDLE). cfg_busy = (state!=IDLE).
- Config writes (cube_we, num_we) take effect only in IDLE; in other states they are dropped silently. K is sampled at transaction accept, so writes never affect an in-flight evaluation.
- Cube memory is not reset. The K register resets to 0, so stale cubes are never evaluated.
- Reset values: state IDLE, out_valid 0, y 0, in_ready 1, cfg_busy 0, K 0.

## Timing
- Input accepted at edge T. Cube i is evaluated in cycle T+1+i. out_valid rises at T+K+1; for K=0 it rises at T+1.
- y is registered and stable while out_valid=1. It changes only on a new transaction.
- Out handshake at edge U: out_valid=0 and in_ready=1 from U+1. There is no same-cycle accept of a new vector during DONE, so at most one transaction is in flight.
- Reset asserted mid-EVAL or mid-DONE drops the transaction immediately. Outputs go to reset values asynchronously.

## Configuration
- ESOP_SEQ_EVAL_PAR2_EN defined: two cubes (index, index+1) are evaluated per EVAL cycle. out_valid rises at T+ceil(K/2)+1 (K=0: T+1). With odd K, the last cycle masks the second cube.
- Undefined: one cube per cycle, with the latencies above. Results are bit-identical in both builds.

## Test plan
- Reset: assert rst mid-run → out_valid=0, y=0, in_ready=1, cfg_busy=0, K=0.
- K=0: x=8'hFF accepted at T → out_valid at T+1, y=0.
- Cube0 = x0 positive (lit0=01), cube1 = x1 positive, masks=1, K=2: x=8'h01 → y=1 at T+3; x=8'h03 → y=0 (cancelling XOR); x=8'h00 → y=0. With PAR2, out_valid is at T+2.
- Negative and never literals: cube0 lit2=10, cube1 lit0=11, masks=1, K=2: x=8'h00 → y=1; x=8'h04 → y=0.
- Backpressure: hold out_ready=0 for 5 cycles → y held stable, in_ready=0, a pending in_valid is not accepted. A cube_we with cube_addr=0 during this window does not alter the subsequent result.
- N_OUT=2, K=3 with masks 01, 10, 11 all matching → y=2'b00. With only cube2 matching, y=2'b11.
